// File: rtl/root_job_dispatcher.sv
// root_job_dispatcher
// -------------------
// Front-end stage for the fixed-point root core. Root jobs (radicand,
// degree, tag) arrive on a valid/ready stream and are queued in a small
// FIFO. Jobs are issued one at a time. The core operands are held steady
// for the whole computation. The 10.10 result is returned with its tag on
// a backpressured result port.
//
// A degree of 0 is answered locally with 1.0 and never reaches the core.
// A watchdog turns a core that never answers into an error result.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset (shared with core)
//   req_valid/ready     job stream handshake
//   req_radicand/exp/tag job fields
//   root_in_valid       one-cycle start pulse to the core
//   root_in_data_1/2    radicand / degree to the core (0 while idle)
//   root_out_valid/data core result pulse and 10.10 value
//   res_valid/ready     result stream handshake
//   res_data/tag/err    result value, job tag, timeout flag
//   busy                job in flight or jobs queued
//   fifo_count          number of queued jobs
module root_job_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 3,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [9:0]       req_radicand,
  input  logic [2:0]       req_exp,
  input  logic [TAG_W-1:0] req_tag,
  output logic             root_in_valid,
  output logic [9:0]       root_in_data_1,
  output logic [2:0]       root_in_data_2,
  input  logic             root_out_valid,
  input  logic [19:0]      root_out_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [19:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int ENT_W = 10 + 3 + TAG_W;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [19:0]      ONE_FIXED = 20'h00400;  // 1.0 in 10.10

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  // ---------------- job FIFO ----------------
  logic [ENT_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ready_reg;

  logic [ENT_W-1:0] head;
  logic [9:0]       head_rad;
  logic [2:0]       head_exp;
  logic [TAG_W-1:0] head_tag;

  logic push, pop;

  // ---------------- control / result registers ----------------
  state_t           state_reg;
  logic [9:0]       job_rad_reg;
  logic [2:0]       job_exp_reg;
  logic [TAG_W-1:0] job_tag_reg;
  logic [TMR_W-1:0] timer_reg;
  logic             in_valid_reg;
  logic             res_valid_reg;
  logic [19:0]      res_data_reg;
  logic [TAG_W-1:0] res_tag_reg;
  logic             res_err_reg;

  assign head     = fifo_mem[rd_ptr_reg];
  assign head_rad = head[ENT_W-1 -: 10];
  assign head_exp = head[TAG_W +: 3];
  assign head_tag = head[TAG_W-1:0];

  assign push = req_valid && ready_reg;
  // A new job is taken only when idle, something is queued (registered
  // count, so a same-cycle push is not visible yet) and no result is pending.
  assign pop  = (state_reg == S_IDLE) && (count_reg != '0) && !res_valid_reg;

  assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_mem[wr_ptr_reg] <= {req_radicand, req_exp, req_tag};
    end
  end

  // req_ready is registered from the next count. It therefore equals
  // (fifo_count < DEPTH) once running, and it reads 0 while in reset. A pop
  // from a full FIFO only reopens the input on the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      ready_reg <= (count_next < DEPTH_C);
    end
  end

  // ---------------- dispatcher FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      job_rad_reg   <= '0;
      job_exp_reg   <= '0;
      job_tag_reg   <= '0;
      timer_reg     <= '0;
      in_valid_reg  <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_tag_reg   <= '0;
      res_err_reg   <= 1'b0;
    end else begin
      in_valid_reg <= 1'b0;
      if (res_valid_reg && res_ready) res_valid_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (pop) begin
            if (head_exp == 3'd0) begin
              // Degree 0: answer 1.0 directly, core untouched.
              res_valid_reg <= 1'b1;
              res_data_reg  <= ONE_FIXED;
              res_tag_reg   <= head_tag;
              res_err_reg   <= 1'b0;
            end else begin
              job_rad_reg  <= head_rad;
              job_exp_reg  <= head_exp;
              job_tag_reg  <= head_tag;
              in_valid_reg <= 1'b1;  // high for the single ISSUE cycle
              state_reg    <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          timer_reg <= '0;
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          timer_reg <= timer_reg + TMR_W'(1);
          // A real result wins over a coincident timeout.
          if (root_out_valid) begin
            res_valid_reg <= 1'b1;
            res_data_reg  <= root_out_data;
            res_tag_reg   <= job_tag_reg;
            res_err_reg   <= 1'b0;
            job_rad_reg   <= '0;
            job_exp_reg   <= '0;
            state_reg     <= S_IDLE;
          end else if (timer_reg == TMR_LAST) begin
            res_valid_reg <= 1'b1;
            res_data_reg  <= '0;
            res_tag_reg   <= job_tag_reg;
            res_err_reg   <= 1'b1;
            job_rad_reg   <= '0;
            job_exp_reg   <= '0;
            state_reg     <= S_IDLE;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = ready_reg;
  assign root_in_valid  = in_valid_reg;
  // Job registers are cleared on the way back to IDLE, so the operands read
  // 0 when idle and stay frozen from ISSUE through WAIT.
  assign root_in_data_1 = job_rad_reg;
  assign root_in_data_2 = job_exp_reg;
  assign res_valid      = res_valid_reg;
  assign res_data       = res_data_reg;
  assign res_tag        = res_tag_reg;
  assign res_err        = res_err_reg;
  assign busy           = (state_reg != S_IDLE) || (count_reg != '0);
  assign fifo_count     = count_reg;

endmodule

// File: tb/tb_root_job_dispatcher.sv
// Directed testbench for root_job_dispatcher with a behavioural core model.
module tb_root_job_dispatcher;
  localparam int DEPTH = 4, CNT_W = 3, TAG_W = 4, TIMEOUT = 512;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [9:0]       req_radicand = '0;
  logic [2:0]       req_exp = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             root_in_valid;
  logic [9:0]       root_in_data_1;
  logic [2:0]       root_in_data_2;
  logic             root_out_valid;
  logic [19:0]      root_out_data;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [19:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int push_cyc = 0;

  root_job_dispatcher #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_radicand(req_radicand), .req_exp(req_exp), .req_tag(req_tag),
    .root_in_valid(root_in_valid), .root_in_data_1(root_in_data_1), .root_in_data_2(root_in_data_2),
    .root_out_valid(root_out_valid), .root_out_data(root_out_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_err(res_err), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- core model ----------------
  bit          core_en = 1'b1;
  bit          core_fixed_en = 1'b0;
  logic [19:0] core_fixed_val = '0;
  int          core_lat = 10;
  int          core_cnt = 0;
  logic [19:0] core_resp = '0;
  int          pulse_count = 0;
  int          pulse_cyc = 0;
  int          hold_bad = 0;
  logic [9:0]  held1 = '0;
  logic [2:0]  held2 = '0;
  bit          stray_req = 1'b0;

  initial begin
    root_out_valid = 1'b0;
    root_out_data  = '0;
    forever begin
      @(negedge clk);
      root_out_valid = 1'b0;
      root_out_data  = '0;
      if (rst_n !== 1'b1) begin
        core_cnt = 0;
      end else begin
        if (core_cnt > 0) begin
          if (root_in_data_1 !== held1 || root_in_data_2 !== held2) hold_bad++;
          core_cnt--;
          if (core_cnt == 0) begin
            root_out_valid = 1'b1;
            root_out_data  = core_resp;
          end
        end
        if (stray_req) begin
          root_out_valid = 1'b1;
          root_out_data  = 20'hABCDE;
          stray_req      = 1'b0;
        end
        if (root_in_valid === 1'b1) begin
          pulse_count++;
          pulse_cyc = cyc;
          held1 = root_in_data_1;
          held2 = root_in_data_2;
          if (core_en) begin
            core_cnt  = core_lat;
            core_resp = core_fixed_en ? core_fixed_val : {10'd0, root_in_data_1};
          end
        end
      end
    end
  end

  // ---------------- result monitor ----------------
  logic [TAG_W-1:0] got_tag[$];
  logic [19:0]      got_data[$];
  logic             got_err[$];

  always @(posedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      got_tag.push_back(res_tag);
      got_data.push_back(res_data);
      got_err.push_back(res_err);
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic push(input logic [9:0] r, input logic [2:0] e, input logic [TAG_W-1:0] t);
    int n = 0;
    req_valid = 1'b1; req_radicand = r; req_exp = e; req_tag = t;
    while (req_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL push_timeout tag=%0d req_ready=%b required 1", t, req_ready);
    end
    push_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_res(input int budget);
    int n = 0;
    while (res_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (res_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL res_wait_timeout res_valid=%b required 1", res_valid);
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, root_in_valid, root_in_data_1, root_in_data_2, res_valid, res_data,
         res_tag, res_err, busy, fifo_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b iv=%b d1=%h d2=%h rv=%b rd=%h rt=%h re=%b busy=%b cnt=%0d required all 0",
               req_ready, root_in_valid, root_in_data_1, root_in_data_2, res_valid, res_data,
               res_tag, res_err, busy, fifo_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b required 1", req_ready); end
    checks++;
    if (fifo_count !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle fifo_count=%0d busy=%b required 0/0", fifo_count, busy);
    end
    $display("reset: released, req_ready=%b", req_ready);
  endtask

  task automatic test_single_job();
    int t, pc0;
    core_en = 1'b1; core_fixed_en = 1'b1; core_fixed_val = 20'h01000; core_lat = 40;
    hold_bad = 0; pc0 = pulse_count;
    push(10'd16, 3'd2, 4'd3);
    t = push_cyc;
    @(negedge clk);  // T+2
    checks++;
    if (root_in_valid !== 1'b1 || root_in_data_1 !== 10'd16 || root_in_data_2 !== 3'd2) begin
      errors++;
      $display("FAIL issue_t2 iv=%b d1=%0d d2=%0d required 1/16/2", root_in_valid, root_in_data_1, root_in_data_2);
    end
    @(negedge clk);
    checks++;
    if (root_in_valid !== 1'b0 || root_in_data_1 !== 10'd16) begin
      errors++; $display("FAIL issue_pulse_width iv=%b d1=%0d required 0/16", root_in_valid, root_in_data_1);
    end
    wait_res(200);
    checks++;
    if (cyc !== t + 43) begin errors++; $display("FAIL single_latency res at %0d required %0d", cyc, t + 43); end
    checks++;
    if (res_data !== 20'h01000 || res_tag !== 4'd3 || res_err !== 1'b0) begin
      errors++; $display("FAIL single_result data=%h tag=%0d err=%b required 01000/3/0", res_data, res_tag, res_err);
    end
    checks++;
    if (pulse_count - pc0 !== 1 || hold_bad !== 0) begin
      errors++; $display("FAIL single_core pulses=%0d hold_bad=%0d required 1/0", pulse_count - pc0, hold_bad);
    end
    checks++;
    if (root_in_data_1 !== 10'd0 || root_in_data_2 !== 3'd0) begin
      errors++; $display("FAIL idle_operands d1=%0d d2=%0d required 0/0", root_in_data_1, root_in_data_2);
    end
    consume();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_consume res_valid=%b busy=%b required 0/0", res_valid, busy);
    end
    $display("single: tag 3 data %h", 20'h01000);
  endtask

  task automatic test_bypass();
    int pc0;
    pc0 = pulse_count;
    push(10'd100, 3'd0, 4'd7);
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL bypass_early res_valid=%b required 0", res_valid); end
    @(negedge clk);  // T+2
    checks++;
    if (res_valid !== 1'b1 || res_data !== 20'h00400 || res_tag !== 4'd7 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL bypass_result rv=%b data=%h tag=%0d err=%b required 1/00400/7/0", res_valid, res_data, res_tag, res_err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pulse_count !== pc0) begin errors++; $display("FAIL bypass_no_pulse pulses=%0d required %0d", pulse_count, pc0); end
    consume();
    $display("bypass: tag 7 data 00400");
  endtask

  task automatic test_back_to_back();
    int n;
    logic [9:0] rad;
    got_tag.delete(); got_data.delete(); got_err.delete();
    core_en = 1'b1; core_fixed_en = 1'b0; core_lat = 60;
    for (int i = 0; i < 5; i++) push(10'(50 + 3 * i), 3'(i % 7 + 1), TAG_W'(i));
    checks++;
    if (fifo_count !== 3'd4 || req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_full fifo_count=%0d req_ready=%b busy=%b required 4/0/1", fifo_count, req_ready, busy);
    end
    res_ready = 1'b1;
    push(10'(50 + 15), 3'd6, TAG_W'(5));
    n = 0;
    while (got_tag.size() < 6 && n < 2000) begin @(negedge clk); n++; end
    res_ready = 1'b0;
    checks++;
    if (got_tag.size() !== 6) begin errors++; $display("FAIL b2b_count got %0d required 6", got_tag.size()); end
    for (int k = 0; k < got_tag.size() && k < 6; k++) begin
      rad = 10'(50 + 3 * k);
      checks++;
      if (got_tag[k] !== TAG_W'(k) || got_data[k] !== {10'd0, rad} || got_err[k] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_order idx=%0d tag=%0d data=%h err=%b required %0d/%h/0", k, got_tag[k], got_data[k], got_err[k], k, {10'd0, rad});
      end
      $display("b2b: result %0d tag %0d data %h", k, got_tag[k], got_data[k]);
    end
  endtask

  task automatic test_backpressure();
    int pc0, bad, n;
    logic [19:0] d0;
    core_en = 1'b1; core_fixed_en = 1'b0; core_lat = 10; res_ready = 1'b0;
    push(10'd200, 3'd3, 4'd1);
    push(10'd201, 3'd4, 4'd2);
    wait_res(100);
    d0 = res_data; pc0 = pulse_count; bad = 0;
    checks++;
    if (d0 !== 20'd200 || res_tag !== 4'd1) begin
      errors++; $display("FAIL bp_first data=%h tag=%0d required 000c8/1", d0, res_tag);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== d0 || res_tag !== 4'd1 || res_err !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_frozen changed_cycles=%0d required 0", bad); end
    checks++;
    if (pulse_count !== pc0 || fifo_count !== 3'd1) begin
      errors++; $display("FAIL bp_no_issue pulses=%0d fifo=%0d required %0d/1", pulse_count, fifo_count, pc0);
    end
    n = cyc;
    consume();           // handshake at end of cycle n, pop in n+1
    @(negedge clk);      // n+2
    checks++;
    if (root_in_valid !== 1'b1 || root_in_data_1 !== 10'd201 || cyc !== n + 2) begin
      errors++; $display("FAIL bp_release iv=%b d1=%0d cyc=%0d required 1/201/%0d", root_in_valid, root_in_data_1, cyc, n + 2);
    end
    wait_res(100);
    checks++;
    if (res_data !== 20'd201 || res_tag !== 4'd2 || res_err !== 1'b0) begin
      errors++; $display("FAIL bp_second data=%h tag=%0d err=%b required 000c9/2/0", res_data, res_tag, res_err);
    end
    consume();
    $display("backpressure: held 30 cycles, tags 1 then 2");
  endtask

  task automatic test_timeout();
    int t, pcr;
    core_en = 1'b0; res_ready = 1'b0;
    push(10'd300, 3'd7, 4'd9);
    t = push_cyc;
    wait_res(TIMEOUT + 50);
    checks++;
    if (cyc !== t + 2 + TIMEOUT + 1) begin
      errors++; $display("FAIL timeout_latency res at %0d required %0d", cyc, t + 3 + TIMEOUT);
    end
    checks++;
    if (res_err !== 1'b1 || res_data !== 20'd0 || res_tag !== 4'd9) begin
      errors++; $display("FAIL timeout_result err=%b data=%h tag=%0d required 1/00000/9", res_err, res_data, res_tag);
    end
    consume();
    stray_req = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stray_ignored res_valid=%b busy=%b required 0/0", res_valid, busy);
    end
    core_en = 1'b1; core_fixed_en = 1'b0; core_lat = 5;
    push(10'd77, 3'd2, 4'd10);
    wait_res(50);
    checks++;
    if (res_data !== 20'd77 || res_tag !== 4'd10 || res_err !== 1'b0) begin
      errors++; $display("FAIL after_stray data=%h tag=%0d err=%b required 0004d/10/0", res_data, res_tag, res_err);
    end
    consume();
    $display("timeout: tag 9 err 1, then tag 10 ok");
    // reset while a job is waiting on a silent core
    core_en = 1'b0;
    push(10'd1, 3'd1, 4'd11);
    push(10'd2, 3'd1, 4'd12);
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || fifo_count !== 3'd1) begin
      errors++; $display("FAIL midwait_state busy=%b fifo=%0d required 1/1", busy, fifo_count);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd0 || busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midwait_reset fifo=%0d busy=%b res_valid=%b req_ready=%b required 0/0/0/1", fifo_count, busy, res_valid, req_ready);
    end
    pcr = pulse_count;
    repeat (20) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || pulse_count !== pcr) begin
      errors++; $display("FAIL midwait_silent res_valid=%b pulses=%0d required 0/%0d", res_valid, pulse_count, pcr);
    end
    $display("reset mid-wait: queue flushed, no result");
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_bypass();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
